// File: rtl/timer_pkg.sv
// Shared timer types: FSM states, BCD digit limits and the 4-digit time word.
package timer_pkg;

  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned BCD_UNITS_MAX = 9;
  localparam int unsigned BCD_TENS_MAX  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] min10;
    logic [DIGIT_W-1:0] min01;
    logic [DIGIT_W-1:0] sec10;
    logic [DIGIT_W-1:0] sec01;
  } bcd_time_t;

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown borrow chain: loadable, wraps 0 -> MAX on borrow.
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter int unsigned MAX = BCD_UNITS_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               borrow_in,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow_out
);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  // Next digit: load wins, otherwise step down on an incoming borrow.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (borrow_in) begin
      digit_d = (digit_q == DIGIT_W'(0)) ? DIGIT_W'(MAX) : digit_q - DIGIT_W'(1);
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = (digit_q == DIGIT_W'(0)) && borrow_in;

endmodule

// File: rtl/countdown_timer.sv
// Mm:ss BCD countdown timer with load/start/pause control and expiry flagging.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned MIN10_MAX = BCD_TENS_MAX,
  parameter int unsigned SEC10_MAX = BCD_TENS_MAX
) (
  input  logic       CLK1,
  input  logic       RESET,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] min10,
  input  logic [3:0] min01,
  input  logic [3:0] sec10,
  input  logic [3:0] sec01,
  output logic [3:0] cur_min10,
  output logic [3:0] cur_min01,
  output logic [3:0] cur_sec10,
  output logic [3:0] cur_sec01,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       load_err
);

  state_e    state_q, state_d;
  logic      running_q, running_d;
  logic      expired_q, expired_d;
  logic      done_q, done_d;
  logic      load_err_q, load_err_d;

  bcd_time_t preset_c;
  bcd_time_t cur_c;
  logic      valid_c;
  logic      load_ok_c;
  logic      cur_zero_c;
  logic      cur_one_c;
  logic      dec_c;
  logic      borrow_s10_c, borrow_m01_c, borrow_m10_c;
  // Borrow out of the top digit would mean wrapping 00:00, which dec_c never requests.
  logic      borrow_top_unused;

  // Preset validity and the load/decrement qualifiers derived from state.
  always_comb begin
    preset_c   = {min10, min01, sec10, sec01};
    valid_c    = (preset_c.min01 <= DIGIT_W'(BCD_UNITS_MAX)) &&
                 (preset_c.sec01 <= DIGIT_W'(BCD_UNITS_MAX)) &&
                 (preset_c.min10 <= DIGIT_W'(MIN10_MAX)) &&
                 (preset_c.sec10 <= DIGIT_W'(SEC10_MAX));
    load_ok_c  = load && valid_c && (state_q != ST_RUN);
    cur_zero_c = (cur_c == bcd_time_t'(0));
    cur_one_c  = (cur_c == bcd_time_t'(1));
    dec_c      = (state_q == ST_RUN) && tick && !pause && !cur_zero_c;
  end

  bcd_digit_down #(.MAX(BCD_UNITS_MAX)) u_sec01 (
    .clk(CLK1), .rst(RESET), .borrow_in(dec_c), .load(load_ok_c),
    .load_val(preset_c.sec01), .digit(cur_c.sec01), .borrow_out(borrow_s10_c)
  );

  bcd_digit_down #(.MAX(SEC10_MAX)) u_sec10 (
    .clk(CLK1), .rst(RESET), .borrow_in(borrow_s10_c), .load(load_ok_c),
    .load_val(preset_c.sec10), .digit(cur_c.sec10), .borrow_out(borrow_m01_c)
  );

  bcd_digit_down #(.MAX(BCD_UNITS_MAX)) u_min01 (
    .clk(CLK1), .rst(RESET), .borrow_in(borrow_m01_c), .load(load_ok_c),
    .load_val(preset_c.min01), .digit(cur_c.min01), .borrow_out(borrow_m10_c)
  );

  bcd_digit_down #(.MAX(MIN10_MAX)) u_min10 (
    .clk(CLK1), .rst(RESET), .borrow_in(borrow_m10_c), .load(load_ok_c),
    .load_val(preset_c.min10), .digit(cur_c.min10), .borrow_out(borrow_top_unused)
  );

  // Next state and next registered flags; load beats start, pause beats tick.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    load_err_d = load && !valid_c && (state_q != ST_RUN);
    case (state_q)
      ST_IDLE: begin
        if (!load_ok_c && start && !cur_zero_c) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pause) begin
          state_d = ST_PAUSE;
        end else if (tick && cur_one_c) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (load_ok_c)  state_d = ST_IDLE;
        else if (start) state_d = ST_RUN;
      end
      ST_DONE: begin
        if (load_ok_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_DONE);
  end

  // State and flag registers.
  always_ff @(posedge CLK1) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      running_q  <= running_d;
      expired_q  <= expired_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign cur_min10 = cur_c.min10;
  assign cur_min01 = cur_c.min01;
  assign cur_sec10 = cur_c.sec10;
  assign cur_sec01 = cur_c.sec01;
  assign running   = running_q;
  assign expired   = expired_q;
  assign done      = done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed vector table, corner sequences, random vs. seconds model.
module tb_countdown_timer;

  logic       CLK1 = 1'b0;
  logic       RESET, tick, load, start, pause;
  logic [3:0] min10, min01, sec10, sec01;
  logic [3:0] cur_min10, cur_min01, cur_sec10, cur_sec01;
  logic       running, expired, done, load_err;

  int checks = 0;
  int failures = 0;

  always #5 CLK1 = ~CLK1;

  countdown_timer dut (
    .CLK1(CLK1), .RESET(RESET), .tick(tick), .load(load), .start(start), .pause(pause),
    .min10(min10), .min01(min01), .sec10(sec10), .sec01(sec01),
    .cur_min10(cur_min10), .cur_min01(cur_min01), .cur_sec10(cur_sec10), .cur_sec01(cur_sec01),
    .running(running), .expired(expired), .done(done), .load_err(load_err)
  );

  // Expected values: cur as 16-bit BCD, flags as {running, expired, done, load_err}.
  typedef struct {
    logic        rst, tk, ld, st, ps;
    logic [15:0] preset;
    logic [15:0] cur;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic r, t, l, s, p, input logic [15:0] pre,
                      input logic [15:0] c, input logic [3:0] f);
    vec_t v;
    v.rst = r; v.tk = t; v.ld = l; v.st = s; v.ps = p;
    v.preset = pre; v.cur = c; v.flags = f;
    vecs.push_back(v);
  endtask

  // Apply inputs for one cycle; return 1 ns after the active edge.
  task automatic drive(input logic r, t, l, s, p, input logic [15:0] pre);
    RESET = r; tick = t; load = l; start = s; pause = p;
    {min10, min01, sec10, sec01} = pre;
    @(posedge CLK1);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] ecur, input logic [3:0] eflags);
    logic [15:0] acur;
    logic [3:0]  aflags;
    acur   = {cur_min10, cur_min01, cur_sec10, cur_sec01};
    aflags = {running, expired, done, load_err};
    checks++;
    if (acur !== ecur || aflags !== eflags) begin
      failures++;
      $display("FAIL %s: got cur=%h run/exp/done/err=%b, want cur=%h run/exp/done/err=%b",
               name, acur, aflags, ecur, eflags);
    end
  endtask

  // Seconds <-> BCD conversion for the reference model.
  function automatic logic [15:0] to_bcd(input int r);
    return {4'(r / 600), 4'((r / 60) % 10), 4'((r % 60) / 10), 4'(r % 10)};
  endfunction

  function automatic int to_secs(input logic [15:0] p);
    return int'(p[15:12]) * 600 + int'(p[11:8]) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
  endfunction

  function automatic bit preset_ok(input logic [15:0] p);
    return (p[15:12] <= 4'd5) && (p[11:8] <= 4'd9) && (p[7:4] <= 4'd5) && (p[3:0] <= 4'd9);
  endfunction

  // Reference model: remaining seconds plus a mode (0 idle, 1 run, 2 paused, 3 done).
  int m_rem, m_mode;
  bit m_done, m_err;

  task automatic model_step(input logic r, t, l, s, p, input logic [15:0] pre);
    bit ok;
    ok = l && preset_ok(pre);
    m_done = 0;
    m_err = 0;
    if (r) begin
      m_rem = 0; m_mode = 0;
    end else begin
      case (m_mode)
        0: begin
          if (l && !ok) m_err = 1;
          if (ok) m_rem = to_secs(pre);
          else if (s && m_rem != 0) m_mode = 1;
        end
        1: begin
          if (p) m_mode = 2;
          else if (t) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin m_mode = 3; m_done = 1; end
          end
        end
        2: begin
          if (l && !ok) m_err = 1;
          if (ok) begin m_rem = to_secs(pre); m_mode = 0; end
          else if (s) m_mode = 1;
        end
        default: begin
          if (l && !ok) m_err = 1;
          if (ok) begin m_rem = to_secs(pre); m_mode = 0; end
        end
      endcase
    end
  endtask

  initial begin
    RESET = 1'b1; tick = 0; load = 0; start = 0; pause = 0;
    {min10, min01, sec10, sec01} = 16'h0000;

    // Directed table: r t l s p preset -> cur flags
    addv(1,0,0,0,0, 16'h0000, 16'h0000, 4'b0000); // reset state
    addv(0,0,1,0,0, 16'h0A00, 16'h0000, 4'b0001); // min01=10 rejected
    addv(0,0,1,0,0, 16'h6000, 16'h0000, 4'b0001); // min10=6 rejected
    addv(0,0,0,0,0, 16'h0000, 16'h0000, 4'b0000); // err pulse clears
    addv(0,0,1,0,0, 16'h0100, 16'h0100, 4'b0000); // load 01:00
    addv(0,0,0,1,0, 16'h0000, 16'h0100, 4'b1000); // start
    addv(0,1,0,0,0, 16'h0000, 16'h0059, 4'b1000); // tick -> 00:59
    addv(0,1,0,0,1, 16'h0000, 16'h0059, 4'b0000); // pause beats tick
    addv(0,1,0,0,0, 16'h0000, 16'h0059, 4'b0000); // tick ignored in pause
    addv(0,0,0,1,0, 16'h0000, 16'h0059, 4'b1000); // resume
    addv(0,1,0,0,0, 16'h0000, 16'h0058, 4'b1000); // tick -> 00:58
    addv(0,0,0,0,1, 16'h0000, 16'h0058, 4'b0000); // pause
    addv(0,0,1,0,0, 16'h0060, 16'h0058, 4'b0001); // sec10=6 rejected in pause
    addv(0,0,0,0,0, 16'h0000, 16'h0058, 4'b0000); // still paused
    addv(0,0,1,0,0, 16'h0000, 16'h0000, 4'b0000); // load 00:00 -> idle
    addv(0,0,0,1,0, 16'h0000, 16'h0000, 4'b0000); // start at 00:00 ignored
    addv(0,0,1,1,0, 16'h0200, 16'h0200, 4'b0000); // load beats start
    addv(0,0,0,1,0, 16'h0000, 16'h0200, 4'b1000); // start
    addv(0,1,0,0,0, 16'h0000, 16'h0159, 4'b1000); // 02:00 -> 01:59
    addv(0,0,1,1,0, 16'h0500, 16'h0159, 4'b1000); // load/start ignored in run
    addv(0,0,0,0,1, 16'h0000, 16'h0159, 4'b0000); // pause
    addv(0,0,1,1,0, 16'h1000, 16'h1000, 4'b0000); // load beats start in pause
    addv(0,0,0,1,0, 16'h0000, 16'h1000, 4'b1000); // start
    addv(0,1,0,0,0, 16'h0000, 16'h0959, 4'b1000); // full borrow chain
    addv(0,1,0,0,0, 16'h0000, 16'h0958, 4'b1000); // back-to-back tick
    addv(1,1,0,0,0, 16'h0000, 16'h0000, 4'b0000); // reset mid-run

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].tk, vecs[i].ld, vecs[i].st, vecs[i].ps, vecs[i].preset);
      check($sformatf("vec%0d", i), vecs[i].cur, vecs[i].flags);
    end

    // Full minute countdown to expiry with consecutive ticks.
    drive(0,0,1,0,0, 16'h0100);
    drive(0,0,0,1,0, 16'h0000);
    for (int i = 1; i <= 60; i++) begin
      drive(0,1,0,0,0, 16'h0000);
      check($sformatf("minute_tick%0d", i), to_bcd(60 - i),
            (i == 60) ? 4'b0110 : 4'b1000);
    end
    drive(0,0,0,0,0, 16'h0000);
    check("done_clears", 16'h0000, 4'b0100);
    drive(0,1,0,1,0, 16'h0000);
    check("start_in_done", 16'h0000, 4'b0100);
    drive(0,0,1,0,0, 16'h0003);
    check("reload_from_done", 16'h0003, 4'b0000);
    drive(0,0,0,1,0, 16'h0000);
    check("restart", 16'h0003, 4'b1000);
    drive(0,1,0,0,0, 16'h0000);
    check("t3_1", 16'h0002, 4'b1000);
    drive(0,1,0,0,0, 16'h0000);
    check("t3_2", 16'h0001, 4'b1000);
    drive(0,1,0,0,0, 16'h0000);
    check("t3_expire", 16'h0000, 4'b0110);

    // Reset at 02:30 while running, with a tick in the reset cycle.
    drive(0,0,1,0,0, 16'h0230);
    drive(0,0,0,1,0, 16'h0000);
    check("run_0230", 16'h0230, 4'b1000);
    drive(1,1,0,0,0, 16'h0000);
    check("reset_run", 16'h0000, 4'b0000);
    drive(0,1,0,0,0, 16'h0000);
    check("after_reset", 16'h0000, 4'b0000);

    // Random stimulus against the seconds model.
    drive(1,0,0,0,0, 16'h0000);
    m_rem = 0; m_mode = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r, t, l, s, p;
      logic [15:0] pre;
      r = ($urandom_range(0, 299) == 0);
      t = $urandom_range(0, 1) == 1;
      l = ($urandom_range(0, 24) == 0);
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 14) == 0);
      pre[15:12] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 7)) : 4'd0;
      pre[11:8]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 10)) : 4'd0;
      pre[7:4]   = 4'($urandom_range(0, 6));
      pre[3:0]   = 4'($urandom_range(0, 10));
      if (l && !preset_ok(pre)) s = 0;
      model_step(r, t, l, s, p, pre);
      drive(r, t, l, s, p, pre);
      check($sformatf("rand%0d", n), to_bcd(m_rem),
            {m_mode == 1, m_mode == 3, m_done, m_err});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
